// File: rtl/fwrisc_trace_pkg.sv
// Shared trace definitions: event kind codes and entry field widths.
// Also used by the tracer BFM, so keep the encoding stable.
package fwrisc_trace_pkg;

  localparam int unsigned TRACE_KIND_W  = 2;
  localparam int unsigned TRACE_ADDR_W  = 32;
  localparam int unsigned TRACE_DATA_W  = 32;
  localparam int unsigned TRACE_STRB_W  = 4;
  localparam int unsigned TRACE_RADDR_W = 6;

  localparam logic [TRACE_KIND_W-1:0] TRACE_KIND_INSTR = 2'd0;
  localparam logic [TRACE_KIND_W-1:0] TRACE_KIND_REG   = 2'd1;
  localparam logic [TRACE_KIND_W-1:0] TRACE_KIND_MEM   = 2'd2;

  // Payload layout inside a FIFO entry: {addr, data, strb}; the timestamp sits above it.
  localparam int unsigned TRACE_PAYLOAD_W = TRACE_ADDR_W + TRACE_DATA_W + TRACE_STRB_W;
  localparam int unsigned TRACE_STRB_LSB  = 0;
  localparam int unsigned TRACE_DATA_LSB  = TRACE_STRB_W;
  localparam int unsigned TRACE_ADDR_LSB  = TRACE_STRB_W + TRACE_DATA_W;

  function automatic logic [TRACE_PAYLOAD_W-1:0] trace_pack(
    input logic [TRACE_ADDR_W-1:0] addr,
    input logic [TRACE_DATA_W-1:0] data,
    input logic [TRACE_STRB_W-1:0] strb
  );
    return {addr, data, strb};
  endfunction

endpackage

// File: rtl/fwrisc_trace_arbiter_if.sv
// Valid/ready trace event stream between the arbiter and the tracer BFM.
interface fwrisc_trace_arbiter_if #(
  parameter int unsigned TS_WIDTH = 16
) ();
  import fwrisc_trace_pkg::*;

  logic                    ev_valid;
  logic                    ev_ready;
  logic [TRACE_KIND_W-1:0] ev_kind;
  logic [TRACE_ADDR_W-1:0] ev_addr;
  logic [TRACE_DATA_W-1:0] ev_data;
  logic [TRACE_STRB_W-1:0] ev_strb;
  logic [TS_WIDTH-1:0]     ev_time;

  modport master (
    output ev_valid,
    input  ev_ready,
    output ev_kind,
    output ev_addr,
    output ev_data,
    output ev_strb,
    output ev_time
  );

  modport slave (
    input  ev_valid,
    output ev_ready,
    input  ev_kind,
    input  ev_addr,
    input  ev_data,
    input  ev_strb,
    input  ev_time
  );

endinterface

// File: rtl/fwrisc_trace_fifo.sv
// Synchronous FIFO with extra-bit pointer wrap. A push while full is accepted
// only when a pop happens in the same cycle.
module fwrisc_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/fwrisc_trace_arbiter.sv
// Merges instr-retire, reg-write and mem-write trace events into one ordered
// valid/ready stream: per-source FIFOs, oldest-first arbiter, registered output.
module fwrisc_trace_arbiter
  import fwrisc_trace_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_WIDTH   = 16,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_instr,
  input  logic                     i_ivalid,
  input  logic [TRACE_RADDR_W-1:0] i_rd_waddr,
  input  logic [31:0]              i_rd_wdata,
  input  logic                     i_rd_write,
  input  logic [31:0]              i_maddr,
  input  logic [31:0]              i_mdata,
  input  logic [3:0]               i_mstrb,
  input  logic                     i_mwrite,
  input  logic                     i_mvalid,
  input  logic                     i_cfg_en_instr,
  input  logic                     i_cfg_en_reg,
  input  logic                     i_cfg_en_mem,
  input  logic                     i_drop_clr,
  fwrisc_trace_arbiter_if.master   ev_if,
  output logic [DROP_WIDTH-1:0]    o_drop_instr,
  output logic [DROP_WIDTH-1:0]    o_drop_reg,
  output logic [DROP_WIDTH-1:0]    o_drop_mem,
  output logic                     o_idle
);

  localparam int unsigned ENTRY_W = TS_WIDTH + TRACE_PAYLOAD_W;
  localparam int unsigned NSRC    = 3;

  logic [TS_WIDTH-1:0]     r_ts;
  logic [NSRC-1:0]         w_cap;
  logic [NSRC-1:0]         w_full;
  logic [NSRC-1:0]         w_empty;
  logic [NSRC-1:0]         w_pop;
  logic [NSRC-1:0]         w_sel;
  logic [NSRC-1:0]         w_drop;
  logic [ENTRY_W-1:0]      w_wdata [NSRC];
  logic [ENTRY_W-1:0]      w_head  [NSRC];
  logic [TS_WIDTH-1:0]     w_age   [NSRC];
  logic [ENTRY_W-1:0]      w_sel_entry;
  logic [TRACE_KIND_W-1:0] w_sel_kind;
  logic                    w_any;
  logic                    w_load;
  logic                    w_instr_ok;
  logic                    w_reg_ok;

  logic                    r_valid;
  logic [TRACE_KIND_W-1:0] r_kind;
  logic [TRACE_ADDR_W-1:0] r_addr;
  logic [TRACE_DATA_W-1:0] r_data;
  logic [TRACE_STRB_W-1:0] r_strb;
  logic [TS_WIDTH-1:0]     r_time;
  logic [DROP_WIDTH-1:0]   r_drop [NSRC];

  always_ff @(posedge i_clock) begin
    if (i_reset) r_ts <= '0;
    else         r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Capture qualification and entry formatting.
  assign w_cap[0] = i_ivalid && i_cfg_en_instr;
  assign w_cap[1] = i_rd_write && (i_rd_waddr != '0) && i_cfg_en_reg;
  assign w_cap[2] = i_mvalid && i_mwrite && i_cfg_en_mem;

  assign w_wdata[0] = {r_ts, trace_pack(i_pc, i_instr, '0)};
  assign w_wdata[1] = {r_ts, trace_pack({{(TRACE_ADDR_W-TRACE_RADDR_W){1'b0}}, i_rd_waddr},
                                        i_rd_wdata, '0)};
  assign w_wdata[2] = {r_ts, trace_pack(i_maddr, i_mdata, i_mstrb)};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwrisc_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (w_cap[g]),
      .i_wdata (w_wdata[g]),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (w_head[g])
    );

    // Modular age keeps ordering correct across timestamp wrap.
    assign w_age[g]  = r_ts - w_head[g][ENTRY_W-1 -: TS_WIDTH];
    assign w_drop[g] = w_cap[g] && w_full[g] && !w_pop[g];
  end

  // Oldest head wins; ">=" on ties gives instr > reg > mem.
  assign w_instr_ok = !w_empty[0] && (w_empty[1] || (w_age[0] >= w_age[1]))
                                  && (w_empty[2] || (w_age[0] >= w_age[2]));
  assign w_reg_ok   = !w_empty[1] && (w_empty[2] || (w_age[1] >= w_age[2]));

  always_comb begin
    w_sel       = '0;
    w_sel_entry = w_head[2];
    w_sel_kind  = TRACE_KIND_MEM;
    if (w_instr_ok) begin
      w_sel       = 3'b001;
      w_sel_entry = w_head[0];
      w_sel_kind  = TRACE_KIND_INSTR;
    end else if (w_reg_ok) begin
      w_sel       = 3'b010;
      w_sel_entry = w_head[1];
      w_sel_kind  = TRACE_KIND_REG;
    end else if (!w_empty[2]) begin
      w_sel = 3'b100;
    end
  end

  assign w_any  = ~&w_empty;
  assign w_load = w_any && (!r_valid || ev_if.ev_ready);
  assign w_pop  = w_load ? w_sel : '0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_kind  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_strb  <= '0;
      r_time  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_kind  <= w_sel_kind;
      r_addr  <= w_sel_entry[TRACE_ADDR_LSB +: TRACE_ADDR_W];
      r_data  <= w_sel_entry[TRACE_DATA_LSB +: TRACE_DATA_W];
      r_strb  <= w_sel_entry[TRACE_STRB_LSB +: TRACE_STRB_W];
      r_time  <= w_sel_entry[ENTRY_W-1 -: TS_WIDTH];
    end else if (ev_if.ev_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle drop; counters saturate at all-ones.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_drop_clr) begin
      for (int s = 0; s < NSRC; s++) r_drop[s] <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (w_drop[s] && !(&r_drop[s])) r_drop[s] <= r_drop[s] + DROP_WIDTH'(1);
      end
    end
  end

  // Masking with reset keeps a stale event from handshaking in the reset cycle.
  assign ev_if.ev_valid = r_valid && !i_reset;
  assign ev_if.ev_kind  = r_kind;
  assign ev_if.ev_addr  = r_addr;
  assign ev_if.ev_data  = r_data;
  assign ev_if.ev_strb  = r_strb;
  assign ev_if.ev_time  = r_time;

  assign o_drop_instr = r_drop[0];
  assign o_drop_reg   = r_drop[1];
  assign o_drop_mem   = r_drop[2];
  assign o_idle       = (&w_empty) && !r_valid;

endmodule
